sdram_pattern_tester: RTL

- Traffic generator and checker that sits directly upstream of SdramCtrl and drives its request/ack port.
- After the power-up wait, it performs two passes over a configurable address window. Each pass writes an address-derived pattern to every word, then reads every word back and compares it.
- Reports progress, error count, first failing address/data and an LED status code.
- Replaces the single-word write/read check with a full-window test.

---
 rtl/sdram_pattern_tester.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_pattern_tester.sv
// ---------------------------------------------------------------------------
// sdram_pattern_tester
//
// Traffic generator / checker placed directly in front of SdramCtrl. After a
// power-up wait it runs two passes over the window START_ADDR ..
// START_ADDR+NUM_WORDS-1. Each pass writes pat(a,p) = a[15:0]^SEED (inverted
// in pass 1) to every word, then reads every word back and compares it.
//
// Ports
//   clk, reset_l          system clock, asynchronous active-low reset
//   start                 one-cycle pulse; re-runs the test from DONE/TIMEOUT
//   sdram_req/ack         request/completion pulses to/from SdramCtrl
//   sdram_addr            word address ({row,col,bank} packing as SdramCtrl)
//   sdram_rh_wl           1 = read, 0 = write
//   sdram_data_w/_r       write data / read data (read data valid with ack)
//   busy                  high while the test is running
//   done                  high in DONE or TIMEOUT, sticky until start/reset
//   err_cnt               saturating mismatch count
//   first_err_addr/_data  address and read data of the first mismatch
//   led                   00 running, 55 pass, AA mismatch(es), FF timeout
//   state_dbg             current FSM state encoding
//
// Handshake: sdram_req is a one-cycle pulse; the request stays outstanding
// until SdramCtrl returns a one-cycle sdram_ack. addr/rh_wl/data_w are held
// from the req cycle through the ack cycle, and no new req is issued while one
// is outstanding. An ack is only honoured in the *_WAIT states; anywhere else
// it is ignored. The req register is loaded in the *_REQ state, so the req
// pulse appears in the first *_WAIT cycle, two cycles after the previous ack.
// ---------------------------------------------------------------------------
module sdram_pattern_tester #(
   parameter int unsigned INIT_WAIT   = 25000,
   parameter logic [23:0] START_ADDR  = 24'h000000,
   parameter int unsigned NUM_WORDS   = 256,
   parameter logic [15:0] SEED        = 16'hF055,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic        clk,
   input  logic        reset_l,
   input  logic        start,
   output logic        sdram_req,
   input  logic        sdram_ack,
   output logic [23:0] sdram_addr,
   output logic        sdram_rh_wl,
   output logic [15:0] sdram_data_w,
   input  logic [15:0] sdram_data_r,
   output logic        busy,
   output logic        done,
   output logic [15:0] err_cnt,
   output logic [23:0] first_err_addr,
   output logic [15:0] first_err_data,
   output logic [7:0]  led,
   output logic [2:0]  state_dbg
);

   localparam int WW = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(INIT_WAIT - 1);
   localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYC);
   localparam logic [23:0]   IDX_LAST  = 24'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_WR_WAIT = 3'd2,
      S_RD_REQ  = 3'd3,
      S_RD_WAIT = 3'd4,
      S_DONE    = 3'd5,
      S_TIMEOUT = 3'd6
   } state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] wcnt, wcnt_nxt;
   // Counts cycles since the req pulse: 0 in the req cycle itself.
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic [23:0]   idx, idx_nxt;
   logic          pass, pass_nxt;

   logic          req_nxt, rh_wl_nxt, busy_nxt, done_nxt;
   logic [23:0]   addr_nxt, fea_nxt;
   logic [15:0]   data_w_nxt, err_nxt, fed_nxt;
   logic [7:0]    led_nxt;
   logic          rd_match;

   function automatic logic [15:0] pat(input logic [23:0] a, input logic p);
      pat = (a[15:0] ^ SEED) ^ {16{p}};
   endfunction

   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state          <= S_INIT;
         wcnt           <= '0;
         tcnt           <= '0;
         idx            <= '0;
         pass           <= 1'b0;
         sdram_req      <= 1'b0;
         sdram_addr     <= '0;
         sdram_rh_wl    <= 1'b1;
         sdram_data_w   <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_cnt        <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
         led            <= '0;
      end else begin
         state          <= state_nxt;
         wcnt           <= wcnt_nxt;
         tcnt           <= tcnt_nxt;
         idx            <= idx_nxt;
         pass           <= pass_nxt;
         sdram_req      <= req_nxt;
         sdram_addr     <= addr_nxt;
         sdram_rh_wl    <= rh_wl_nxt;
         sdram_data_w   <= data_w_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         err_cnt        <= err_nxt;
         first_err_addr <= fea_nxt;
         first_err_data <= fed_nxt;
         led            <= led_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      wcnt_nxt   = wcnt;
      tcnt_nxt   = tcnt;
      idx_nxt    = idx;
      pass_nxt   = pass;
      req_nxt    = 1'b0;
      addr_nxt   = sdram_addr;
      rh_wl_nxt  = sdram_rh_wl;
      data_w_nxt = sdram_data_w;
      busy_nxt   = busy;
      done_nxt   = done;
      err_nxt    = err_cnt;
      fea_nxt    = first_err_addr;
      fed_nxt    = first_err_data;
      led_nxt    = led;
      // sdram_addr is held from the req cycle, so it names the word being read.
      rd_match   = (sdram_data_r == pat(sdram_addr, pass));

      case (state)
         S_INIT: begin
            if (wcnt == WAIT_LAST) begin
               state_nxt = S_WR_REQ;
               idx_nxt   = '0;
               pass_nxt  = 1'b0;
               busy_nxt  = 1'b1;
            end else begin
               wcnt_nxt = wcnt + 1'b1;
            end
         end

         S_WR_REQ: begin
            req_nxt    = 1'b1;
            addr_nxt   = START_ADDR + idx;
            rh_wl_nxt  = 1'b0;
            data_w_nxt = pat(START_ADDR + idx, pass);
            tcnt_nxt   = '0;
            state_nxt  = S_WR_WAIT;
         end

         S_WR_WAIT: begin
            // ack is checked before the terminal count so a late ack still wins.
            if (sdram_ack) begin
               if (idx == IDX_LAST) begin
                  idx_nxt   = '0;
                  state_nxt = S_RD_REQ;
               end else begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = S_WR_REQ;
               end
            end else if (tcnt == TOUT_LAST) begin
               state_nxt = S_TIMEOUT;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               led_nxt   = 8'hFF;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end

         S_RD_REQ: begin
            req_nxt   = 1'b1;
            addr_nxt  = START_ADDR + idx;
            rh_wl_nxt = 1'b1;
            tcnt_nxt  = '0;
            state_nxt = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            if (sdram_ack) begin
               if (!rd_match) begin
                  if (err_cnt != 16'hFFFF) err_nxt = err_cnt + 1'b1;
                  if (err_cnt == 16'h0000) begin
                     fea_nxt = sdram_addr;
                     fed_nxt = sdram_data_r;
                  end
               end
               if (idx == IDX_LAST) begin
                  idx_nxt = '0;
                  if (!pass) begin
                     pass_nxt  = 1'b1;
                     state_nxt = S_WR_REQ;
                  end else begin
                     state_nxt = S_DONE;
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                     // err_nxt includes the compare of this final word.
                     led_nxt   = (err_nxt == 16'h0000) ? 8'h55 : 8'hAA;
                  end
               end else begin
                  idx_nxt   = idx + 1'b1;
                  state_nxt = S_RD_REQ;
               end
            end else if (tcnt == TOUT_LAST) begin
               state_nxt = S_TIMEOUT;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               led_nxt   = 8'hFF;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end

         S_DONE, S_TIMEOUT: begin
            // Re-run skips the power-up wait; the SDRAM is already initialised.
            if (start) begin
               state_nxt = S_WR_REQ;
               err_nxt   = '0;
               fea_nxt   = '0;
               fed_nxt   = '0;
               led_nxt   = '0;
               pass_nxt  = 1'b0;
               idx_nxt   = '0;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
            end
         end

         default: state_nxt = S_INIT;
      endcase
   end

endmodule
